// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
//
// Two-read / one-write register file with a per-register pending-write
// scoreboard. Decode reserves a destination (busy bit set). Writeback commits
// the data and releases the reservation. If a reserve and a write hit the same
// index in one cycle, the reserve wins because it belongs to the newer producer.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, a same-cycle write is forwarded to matching read ports.
//   The forwarded busy flag reflects the same-cycle reserve.
//
// Ports:
//   clk          clock, rising-edge
//   rst          asynchronous active-high reset
//   regWrite     writeback commit enable
//   writeReg     writeback destination index
//   writeData    writeback data
//   rsvValid     reserve request from decode
//   rsvReg       register to mark pending
//   readReg1/2   read port indices
//   readData1/2  combinational read data
//   busy1/2      combinational busy flags of the read indices
//   rsvConflict  reserve targets an already-busy register (advisory)
//   pendingCount registered number of busy registers
// -----------------------------------------------------------------------------
module register_file_sb #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  rsvValid,
    input  logic [ADDR_WIDTH-1:0] rsvReg,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rsvConflict,
    output logic [ADDR_WIDTH:0]   pendingCount
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [ADDR_WIDTH:0]   r_pending;

    logic [DEPTH-1:0]      w_wr_hit;
    logic [DEPTH-1:0]      w_rsv_hit;
    logic [DEPTH-1:0]      w_busy_next;
    logic                  w_inc;
    logic                  w_dec;
    logic [ADDR_WIDTH:0]   w_pending_next;

    // Per-index decode. The hardwired-zero entry never gets a hit, so its data
    // and busy bit stay at their reset value of 0. Read paths therefore need no
    // extra masking for index 0. The hits are gated by rst so that a forwarded
    // value cannot leak onto the outputs while reset is held.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            localparam logic [ADDR_WIDTH-1:0] IDX     = ADDR_WIDTH'(gi);
            localparam bit                    IS_ZERO = (ZERO_REG != 0) && (gi == 0);

            assign w_wr_hit[gi]    = !IS_ZERO && !rst && regWrite && (writeReg == IDX);
            assign w_rsv_hit[gi]   = !IS_ZERO && !rst && rsvValid && (rsvReg == IDX);
            // The reserve wins over the clear: it belongs to the newer producer.
            assign w_busy_next[gi] = w_rsv_hit[gi] | (r_busy[gi] & ~w_wr_hit[gi]);
        end
    endgenerate

    // Incremental population count. At most one bit can be set and one bit
    // can be cleared per cycle. A write that lands on an index being
    // re-reserved clears nothing.
    assign w_inc          = |(w_rsv_hit & ~r_busy);
    assign w_dec          = |(w_wr_hit & r_busy & ~w_rsv_hit);
    assign w_pending_next = r_pending + {{ADDR_WIDTH{1'b0}}, w_inc}
                                      - {{ADDR_WIDTH{1'b0}}, w_dec};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_hit[i]) begin
                    r_mem[i] <= writeData;
                end
            end
            r_busy    <= w_busy_next;
            r_pending <= w_pending_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through forwarding. A forwarded busy flag shows the post-edge state,
    // which is set only if a reserve hits the same index in this cycle.
    assign readData1 = w_wr_hit[readReg1] ? writeData : r_mem[readReg1];
    assign readData2 = w_wr_hit[readReg2] ? writeData : r_mem[readReg2];
    assign busy1     = w_wr_hit[readReg1] ? w_rsv_hit[readReg1] : r_busy[readReg1];
    assign busy2     = w_wr_hit[readReg2] ? w_rsv_hit[readReg2] : r_busy[readReg2];
`else
    assign readData1 = r_mem[readReg1];
    assign readData2 = r_mem[readReg2];
    assign busy1     = r_busy[readReg1];
    assign busy2     = r_busy[readReg2];
`endif

    // Busy bit 0 is never set when ZERO_REG is enabled, so no conflict is
    // ever reported for index 0.
    assign rsvConflict  = rsvValid & r_busy[rsvReg];
    assign pendingCount = r_pending;

endmodule

// File: tb/tb_register_file_sb.sv
// -----------------------------------------------------------------------------
// tb_register_file_sb
//
// Directed scenarios followed by randomized traffic. All of it is checked
// against a behavioural model that is kept as plain arrays. The expected
// pending count is recomputed each time by summing the model's busy flags.
// -----------------------------------------------------------------------------
module tb_register_file_sb;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          regWrite;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic          rsvValid;
    logic [AW-1:0] rsvReg;
    logic [AW-1:0] readReg1;
    logic [AW-1:0] readReg2;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;
    logic          busy1;
    logic          busy2;
    logic          rsvConflict;
    logic [AW:0]   pendingCount;

    always #5 clk = ~clk;

    register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .rsvValid     (rsvValid),
        .rsvReg       (rsvReg),
        .readReg1     (readReg1),
        .readReg2     (readReg2),
        .readData1    (readData1),
        .readData2    (readData2),
        .busy1        (busy1),
        .busy2        (busy2),
        .rsvConflict  (rsvConflict),
        .pendingCount (pendingCount)
    );

    // Behavioural model state
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic int m_count();
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(m_busy[i]);
        return s;
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] idx);
        if (rst || idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (regWrite && writeReg == idx) return writeData;
`endif
        return m_mem[idx];
    endfunction

    function automatic bit m_bz(input logic [AW-1:0] idx);
        if (rst || idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (regWrite && writeReg == idx) return rsvValid && rsvReg == idx;
`endif
        return m_busy[idx];
    endfunction

    // Clock-edge effect: the write happens first, then the reserve, so that
    // the newer producer's reservation survives.
    function automatic void m_edge();
        if (rst) begin
            m_clear();
        end else begin
            if (regWrite && writeReg != 0) begin
                m_mem[writeReg]  = writeData;
                m_busy[writeReg] = 1'b0;
            end
            if (rsvValid && rsvReg != 0) m_busy[rsvReg] = 1'b1;
        end
    endfunction

    task automatic check_all();
        chk("rd1",  readData1, m_rd(readReg1));
        chk("rd2",  readData2, m_rd(readReg2));
        chk("bsy1", busy1, m_bz(readReg1));
        chk("bsy2", busy2, m_bz(readReg2));
        chk("cnfl", rsvConflict, !rst && rsvValid && rsvReg != 0 && m_busy[rsvReg]);
        chk("pend", 64'(pendingCount), 64'(m_count()));
    endtask

    // Check the combinational outputs at the falling edge, advance across the
    // rising edge, and return 1 time unit after it.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic drive(input bit rw, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input bit rv, input logic [AW-1:0] rr,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        regWrite  = rw;
        writeReg  = wr;
        writeData = wd;
        rsvValid  = rv;
        rsvReg    = rr;
        readReg1  = r1;
        readReg2  = r2;
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    localparam logic [63:0] V13 = 64'h3762_35E0_1BB1_1AF2;
    localparam logic [63:0] V14 = 64'h1BB1_1AB1_4DD8_AD18;

    initial begin
        rst = 1'b1;
        drive(0, 0, '0, 0, 0, 0, 0);
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Two writes, then read both back
        drive(1, 13, V13, 0, 0, 13, 14); cycle();
        drive(1, 14, V14, 0, 0, 13, 14); cycle();
        drive(0, 0, '0, 0, 0, 13, 14); #1;
        chk("t2_rd1", readData1, V13);
        chk("t2_rd2", readData2, V14);
        chk("t2_bsy1", busy1, 1'b0);
        chk("t2_bsy2", busy2, 1'b0);
        cycle();

        // Reset asserted in the middle of a cycle clears state immediately
        drive(0, 0, '0, 1, 5, 13, 5); cycle();
        drive(0, 0, '0, 0, 0, 13, 5); #1;
        rst = 1'b1; #1;
        m_clear();
        chk("t1_rd1_async", readData1, 64'h0);
        chk("t1_bsy2_async", busy2, 1'b0);
        chk("t1_pend_async", 64'(pendingCount), 64'h0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("t1_pend_rel", 64'(pendingCount), 64'h0);
        chk("t1_bsy2_rel", busy2, 1'b0);
        chk("t1_rd1_rel", readData1, 64'h0);

        // Double reserve (WAW) followed by the releasing write
        drive(0, 0, '0, 1, 7, 7, 0); #1;
        chk("t3_cnfl_first", rsvConflict, 1'b0);
        cycle();
        drive(0, 0, '0, 1, 7, 7, 0); #1;
        chk("t3_bsy1", busy1, 1'b1);
        chk("t3_cnfl_second", rsvConflict, 1'b1);
        chk("t3_pend", 64'(pendingCount), 64'd1);
        cycle();
        chk("t3_pend_after", 64'(pendingCount), 64'd1);
        drive(1, 7, 64'hA5, 0, 0, 7, 0); cycle();
        drive(0, 0, '0, 0, 0, 7, 0); #1;
        chk("t3_bsy1_rel", busy1, 1'b0);
        chk("t3_rd1_rel", readData1, 64'hA5);
        chk("t3_pend_rel", 64'(pendingCount), 64'd0);

        // Write and reserve to the same busy index in one cycle
        drive(0, 0, '0, 1, 9, 9, 0); cycle();
        drive(1, 9, 64'h55, 1, 9, 9, 0); cycle();
        drive(0, 0, '0, 0, 0, 9, 0); #1;
        chk("t4_rd1", readData1, 64'h55);
        chk("t4_bsy1", busy1, 1'b1);
        chk("t4_pend", 64'(pendingCount), 64'd1);
        drive(1, 9, 64'h55, 0, 0, 9, 0); cycle();

        // Hardwired zero register
        drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0); #1;
        chk("t5_cnfl", rsvConflict, 1'b0);
        cycle();
        drive(0, 0, '0, 0, 0, 0, 0); #1;
        chk("t5_rd1", readData1, 64'h0);
        chk("t5_bsy1", busy1, 1'b0);
        chk("t5_pend", 64'(pendingCount), 64'd0);

        // Same-cycle read of the register being written
        drive(1, 20, 64'h1234, 0, 0, 20, 0); #1;
`ifdef REGFILE_BYPASS_EN
        chk("t6_same_cycle", readData1, 64'h1234);
`else
        chk("t6_same_cycle", readData1, 64'h0);
`endif
        cycle();
        drive(0, 0, '0, 0, 0, 20, 0); #1;
        chk("t6_next_cycle", readData1, 64'h1234);

        // Randomized traffic with a mid-run asynchronous reset
        for (int it = 0; it < 400; it++) begin
            drive($urandom_range(0, 1), pick(), {$urandom(), $urandom()},
                  ($urandom_range(0, 2) != 0), pick(), pick(), pick());
            if ($urandom_range(0, 3) == 0) readReg1 = writeReg;
            if ($urandom_range(0, 3) == 0) readReg2 = rsvReg;
            if (it == 200) begin
                #1 rst = 1'b1;
                #1 m_clear();
                chk("rnd_rst_pend", 64'(pendingCount), 64'h0);
                cycle();
                rst = 1'b0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
